// File: rtl/wvb_rd_arbiter_pkg.sv
// Shared definitions for the waveform-buffer read arbiter and its
// round-robin picker: FSM state encoding, timeout counter width and a
// small index-wrapping helper.
package wvb_rd_arbiter_pkg;

  // Arbiter FSM states; encodings match the legacy include file.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    READ   = 3'd2,
    DONE   = 3'd3,
    HOLD   = 3'd4
  } arb_state_t;

  // Width of the READ-state timeout counter.
  localparam int unsigned TO_CNT_W = 16;

  // Next index after idx in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wvb_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of cand
// searching upward from last_grant+1 and wrapping at P_N-1 back to 0.
// Shared with the trigger and readout schedulers.
module rr_pick
  import wvb_rd_arbiter_pkg::*;
#(
  parameter int unsigned P_N = 24,
  parameter int unsigned P_W = 5
) (
  input  logic [P_N-1:0] cand,
  input  logic [P_W-1:0] last_grant,
  output logic [P_W-1:0] winner,
  output logic           valid
);

  logic [2*P_N-1:0] dbl;
  logic [P_N-1:0]   rot;
  int unsigned      lg;
  int unsigned      start;
  int unsigned      off;
  int unsigned      idx;

  // Rotate the request vector so the search start sits at bit 0, then
  // take the lowest set bit and map its offset back to a channel index.
  always_comb begin
    lg    = 32'(last_grant);
    // An out-of-range last_grant restarts the search at index 0.
    start = (lg >= P_N) ? 0 : wrap_inc(lg, P_N);
    dbl   = {cand, cand};
    rot   = P_N'(dbl >> start);
    valid = 1'b0;
    off   = 0;
    for (int unsigned i = 0; i < P_N; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        off   = i;
      end
    end
    idx = start + off;
    if (idx >= P_N) begin
      idx = idx - P_N;
    end
    winner = P_W'(idx);
  end

endmodule

// File: rtl/wvb_rd_arbiter.sv
// Round-robin read scheduler for the per-channel waveform buffers.
// Picks a channel with a pending header, starts the shared readout
// engine on it, waits for completion (or timeout) and then pulses that
// channel's wvb_rddone so its overflow controller can release the event.
module wvb_rd_arbiter
  import wvb_rd_arbiter_pkg::*;
#(
  parameter int unsigned P_N_CHAN     = 24,
  parameter int unsigned P_CHAN_WIDTH = 5,
  parameter int unsigned P_TIMEOUT    = 65535,
  parameter int unsigned P_OVFL_PRIO  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [P_N_CHAN-1:0]     chan_mask,
  input  logic [P_N_CHAN-1:0]     hdr_empty,
  input  logic [P_N_CHAN-1:0]     overflow,
  output logic                    rd_start,
  output logic [P_CHAN_WIDTH-1:0] rd_chan,
  input  logic                    rd_done,
  output logic [P_N_CHAN-1:0]     wvb_rddone,
  output logic                    busy,
  output logic                    timeout_err,
  input  logic                    err_clr,
  output logic [31:0]             rd_count
);

  localparam logic [TO_CNT_W-1:0] TO_LAST =
    (P_TIMEOUT == 0) ? '0 : TO_CNT_W'(P_TIMEOUT - 1);

  arb_state_t state;
  arb_state_t state_nxt;

  logic                    en_q;
  logic [P_N_CHAN-1:0]     mask_q;
  logic [P_N_CHAN-1:0]     empty_q;
  logic [P_N_CHAN-1:0]     ovfl_q;

  logic [P_N_CHAN-1:0]     req;
  logic [P_N_CHAN-1:0]     cand;
  logic [P_CHAN_WIDTH-1:0] last_grant;
  logic [P_CHAN_WIDTH-1:0] pick_chan;
  logic                    pick_valid;

  logic [TO_CNT_W-1:0]     to_cnt;
  logic                    to_hit;

  // Register the request-side inputs; arbitration only ever looks at
  // these copies, so the channel flags are sampled once per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      mask_q  <= '0;
      empty_q <= '1;
      ovfl_q  <= '0;
    end else begin
      en_q    <= en;
      mask_q  <= chan_mask;
      empty_q <= hdr_empty;
      ovfl_q  <= overflow;
    end
  end

  // Candidate vector: eligible channels with a pending header, narrowed
  // to overflowing channels when any of those are requesting.
  always_comb begin
    req = mask_q & ~empty_q;
    if ((P_OVFL_PRIO != 0) && (|(req & ovfl_q))) begin
      cand = req & ovfl_q;
    end else begin
      cand = req;
    end
    to_hit = (P_TIMEOUT != 0) && (to_cnt == TO_LAST);
  end

  rr_pick #(
    .P_N (P_N_CHAN),
    .P_W (P_CHAN_WIDTH)
  ) u_pick (
    .cand       (cand),
    .last_grant (last_grant),
    .winner     (pick_chan),
    .valid      (pick_valid)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    wvb_rddone = '0;
    for (int unsigned i = 0; i < P_N_CHAN; i++) begin
      wvb_rddone[i] = (state == DONE) && (rd_chan == P_CHAN_WIDTH'(i));
    end
    case (state)
      IDLE: begin
        if (en_q && (|cand)) begin
          state_nxt = SELECT;
        end
      end
      SELECT: begin
        // Requests may vanish between IDLE and SELECT; fall back to IDLE.
        state_nxt = pick_valid ? READ : IDLE;
      end
      READ: begin
        if (rd_done || to_hit) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: grant register, start pulse, timeout counter, round-robin
  // pointer, completed-read counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_chan     <= '0;
      rd_start    <= 1'b0;
      last_grant  <= P_CHAN_WIDTH'(P_N_CHAN - 1);
      to_cnt      <= '0;
      timeout_err <= 1'b0;
      rd_count    <= '0;
    end else begin
      rd_start <= (state == SELECT) && pick_valid;

      if ((state == SELECT) && pick_valid) begin
        rd_chan <= pick_chan;
      end

      if (state == SELECT) begin
        to_cnt <= '0;
      end else if (state == READ) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (state == DONE) begin
        last_grant <= rd_chan;
        rd_count   <= rd_count + 32'd1;
      end

      // rd_done beats a coincident timeout; a new timeout beats err_clr.
      if ((state == READ) && !rd_done && to_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wvb_rd_arbiter.sv
// Directed bench for wvb_rd_arbiter. Two instances: u0 with overflow
// priority and a 16-cycle timeout, u1 without priority or timeout.
// Expected grants are queued before each read and popped when rd_start
// fires.
module tb_wvb_rd_arbiter;

  localparam int unsigned N  = 24;
  localparam int unsigned CW = 5;

  typedef struct {
    logic [CW-1:0] chan;
    bit            to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          en_s      [2];
  logic [N-1:0]  mask_s    [2];
  logic [N-1:0]  empty_s   [2];
  logic [N-1:0]  ovfl_s    [2];
  logic          rd_done_s [2];
  logic          err_clr_s [2];
  logic          rd_start_s[2];
  logic [CW-1:0] rd_chan_s [2];
  logic [N-1:0]  rddone_s  [2];
  logic          busy_s    [2];
  logic          terr_s    [2];
  logic [31:0]   cnt_s     [2];

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_cnt[2];
  exp_t        sb[$];

  wvb_rd_arbiter #(
    .P_N_CHAN     (24),
    .P_CHAN_WIDTH (5),
    .P_TIMEOUT    (16),
    .P_OVFL_PRIO  (1)
  ) u0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en_s[0]),
    .chan_mask   (mask_s[0]),
    .hdr_empty   (empty_s[0]),
    .overflow    (ovfl_s[0]),
    .rd_start    (rd_start_s[0]),
    .rd_chan     (rd_chan_s[0]),
    .rd_done     (rd_done_s[0]),
    .wvb_rddone  (rddone_s[0]),
    .busy        (busy_s[0]),
    .timeout_err (terr_s[0]),
    .err_clr     (err_clr_s[0]),
    .rd_count    (cnt_s[0])
  );

  wvb_rd_arbiter #(
    .P_N_CHAN     (24),
    .P_CHAN_WIDTH (5),
    .P_TIMEOUT    (0),
    .P_OVFL_PRIO  (0)
  ) u1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en_s[1]),
    .chan_mask   (mask_s[1]),
    .hdr_empty   (empty_s[1]),
    .overflow    (ovfl_s[1]),
    .rd_start    (rd_start_s[1]),
    .rd_chan     (rd_chan_s[1]),
    .rd_done     (rd_done_s[1]),
    .wvb_rddone  (rddone_s[1]),
    .busy        (busy_s[1]),
    .timeout_err (terr_s[1]),
    .err_clr     (err_clr_s[1]),
    .rd_count    (cnt_s[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [CW-1:0] c, input bit t);
    sb.push_back('{chan: c, to: t});
  endtask

  // Wait for a grant on instance d, compare it with the scoreboard head,
  // complete the read (rd_done after dly cycles, or let it time out) and
  // check the release pulse. Returns in the HOLD cycle.
  task automatic serve(input int unsigned d, input int unsigned dly, input bit drop_en);
    exp_t          e;
    int unsigned   n;
    logic [N-1:0]  oh;
    n = 0;
    while (rd_start_s[d] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (rd_start_s[d] !== 1'b1) begin
      check("rd_start_wait", 32'(rd_start_s[d]), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check("sb_level", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("grant_chan", 32'(rd_chan_s[d]), 32'(e.chan));
    if (drop_en) en_s[d] = 1'b0;
    if (e.to) begin
      n = 0;
      while (rddone_s[d] == '0 && n < 40) begin
        tick();
        n++;
        if (n == 1) check("rd_start_pulse", 32'(rd_start_s[d]), 32'd0);
        check("chan_stable", 32'(rd_chan_s[d]), 32'(e.chan));
      end
      check("timeout_len", n, 32'd16);
    end else begin
      for (int unsigned i = 0; i < dly; i++) begin
        tick();
        if (i == 0) check("rd_start_pulse", 32'(rd_start_s[d]), 32'd0);
        check("chan_stable", 32'(rd_chan_s[d]), 32'(e.chan));
      end
      rd_done_s[d] = 1'b1;
      tick();
      rd_done_s[d] = 1'b0;
    end
    oh = '0;
    oh[e.chan] = 1'b1;
    check("rddone_onehot", 32'(rddone_s[d]), 32'(oh));
    check("done_chan", 32'(rd_chan_s[d]), 32'(e.chan));
    check("timeout_err", 32'(terr_s[d]), 32'(e.to));
    tick();
    exp_cnt[d]++;
    check("rddone_width", 32'(rddone_s[d]), 32'd0);
    check("hold_busy", 32'(busy_s[d]), 32'd1);
    check("rd_count", cnt_s[d], exp_cnt[d]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned seen;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en_s[d]      = 1'b0;
      mask_s[d]    = '1;
      empty_s[d]   = '1;
      ovfl_s[d]    = '0;
      rd_done_s[d] = 1'b0;
      err_clr_s[d] = 1'b0;
      exp_cnt[d]   = 0;
    end

    // Reset state, with channel 3 already requesting on u0.
    en_s[0]       = 1'b1;
    empty_s[0][3] = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", 32'(busy_s[d]), 32'd0);
      check("rst_rd_start", 32'(rd_start_s[d]), 32'd0);
      check("rst_rddone", 32'(rddone_s[d]), 32'd0);
      check("rst_terr", 32'(terr_s[d]), 32'd0);
      check("rst_rd_chan", 32'(rd_chan_s[d]), 32'd0);
      check("rst_count", cnt_s[d], 32'd0);
    end

    // Start latency: IDLE sees the request, SELECT, then READ with rd_start.
    rst_n = 1'b1;
    tick();
    check("lat_idle_start", 32'(rd_start_s[0]), 32'd0);
    check("lat_idle_busy", 32'(busy_s[0]), 32'd0);
    tick();
    check("lat_select_busy", 32'(busy_s[0]), 32'd1);
    check("lat_select_start", 32'(rd_start_s[0]), 32'd0);
    tick();
    check("lat_rd_start", 32'(rd_start_s[0]), 32'd1);
    push(3, 1'b0);
    serve(0, 9, 1'b0);
    empty_s[0] = '1;

    // Round robin without overflow priority; overflow[20] must be ignored.
    en_s[1]        = 1'b1;
    empty_s[1][2]  = 1'b0;
    empty_s[1][5]  = 1'b0;
    empty_s[1][20] = 1'b0;
    ovfl_s[1][20]  = 1'b1;
    push(2, 1'b0); push(5, 1'b0); push(20, 1'b0); push(2, 1'b0); push(5, 1'b0);
    serve(1, 4, 1'b0);
    serve(1, 20, 1'b0);
    serve(1, 0, 1'b0);
    serve(1, 2, 1'b0);
    serve(1, 6, 1'b0);
    empty_s[1] = '1;
    en_s[1]    = 1'b0;

    // Overflow priority: 20 first, then normal rotation once it drops.
    empty_s[0][2]  = 1'b0;
    empty_s[0][5]  = 1'b0;
    empty_s[0][20] = 1'b0;
    ovfl_s[0][20]  = 1'b1;
    push(20, 1'b0);
    serve(0, 2, 1'b0);
    ovfl_s[0] = '0;
    push(2, 1'b0);
    serve(0, 1, 1'b0);
    push(5, 1'b0);
    serve(0, 3, 1'b0);
    push(20, 1'b0);
    serve(0, 0, 1'b0);
    empty_s[0] = '1;

    // Timeout on channel 9, sticky flag, then clear.
    empty_s[0][9] = 1'b0;
    push(9, 1'b1);
    serve(0, 0, 1'b0);
    empty_s[0] = '1;
    tick();
    check("terr_sticky", 32'(terr_s[0]), 32'd1);
    err_clr_s[0] = 1'b1;
    tick();
    err_clr_s[0] = 1'b0;
    check("terr_cleared", 32'(terr_s[0]), 32'd0);

    // Reset in the middle of a read on channel 7.
    empty_s[0][7] = 1'b0;
    n = 0;
    while (rd_start_s[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ch7_rd_start", 32'(rd_start_s[0]), 32'd1);
    check("ch7_grant", 32'(rd_chan_s[0]), 32'd7);
    tick();
    tick();
    empty_s[0][12] = 1'b0;
    rst_n = 1'b0;
    tick();
    check("midrst_busy", 32'(busy_s[0]), 32'd0);
    check("midrst_rddone", 32'(rddone_s[0]), 32'd0);
    check("midrst_count", cnt_s[0], 32'd0);
    check("midrst_count_u1", cnt_s[1], 32'd0);
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    rst_n = 1'b1;
    push(7, 1'b0);
    serve(0, 3, 1'b0);
    push(12, 1'b0);
    serve(0, 1, 1'b0);
    empty_s[0] = '1;

    // Only requester masked off; stray rd_done while idle is ignored.
    empty_s[0][4] = 1'b0;
    mask_s[0][4]  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) rd_done_s[0] = 1'b1;
      if (i == 4) rd_done_s[0] = 1'b0;
      tick();
      if (rd_start_s[0] === 1'b1 || busy_s[0] === 1'b1) seen++;
    end
    check("masked_no_start", seen, 32'd0);
    check("stray_rd_done", cnt_s[0], exp_cnt[0]);

    // en dropped mid-read: read completes, no new arbitration follows.
    mask_s[0] = '1;
    push(4, 1'b0);
    serve(0, 5, 1'b1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy_s[0] === 1'b1) seen++;
    end
    check("en_off_no_select", seen, 32'd0);
    empty_s[0] = '1;
    en_s[0]    = 1'b1;

    // Wrap-around: after serving 23, channel 0 wins over 23.
    empty_s[0][23] = 1'b0;
    push(23, 1'b0);
    serve(0, 2, 1'b0);
    empty_s[0][0] = 1'b0;
    push(0, 1'b0);
    serve(0, 2, 1'b0);
    push(23, 1'b0);
    serve(0, 1, 1'b0);
    empty_s[0] = '1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
